arbiter_x4: RTL

- Four-requester arbiter that shares one downstream resource, such as the shared 7-segment/output datapath behind the 4x2 priority encoder.
- Samples a 4-bit request vector and issues a one-hot grant plus a 2-bit encoded owner index with a valid flag.
- Holds the grant until the owner signals done, drops its request, or hits a hold timeout.
- Sits between requesters and the shared resource; the encoded index drives the resource mux select.

---
 rtl/arbiter_x4.sv | 142 ++++++++++++++
 1 files changed

// File: rtl/arbiter_x4.sv
// rtl/arbiter_x4.sv - four-requester arbiter with hold timeout and one-cycle release gap
// Optional macro ARBITER_X4_ROUND_ROBIN_EN selects round-robin instead of fixed priority.
module arbiter_x4 #(
    parameter int HOLD_MAX = 8,
    parameter int CNT_W    = 8
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       enable,
    input  logic [3:0] req,
    input  logic       done,
    output logic [3:0] grant,
    output logic [1:0] out,
    output logic       flag,
    output logic       timeout
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        GRANT = 2'd1,
        GAP   = 2'd2
    } state_t;

    state_t             state_q, state_d;
    logic [3:0]         grant_d;
    logic [1:0]         out_d;
    logic               flag_d;
    logic               timeout_d;
    logic [CNT_W-1:0]   count_q, count_d;
    logic [1:0]         last_q, last_d;
    logic [1:0]         win;
    logic               release_now;
    logic               hold_expired;

`ifdef ARBITER_X4_ROUND_ROBIN_EN
    logic       found;
    logic [1:0] idx;

    // Search starts just past the previous owner and wraps; first set request wins.
    always_comb begin
        win   = 2'd0;
        found = 1'b0;
        idx   = 2'd0;
        for (int i = 0; i < 4; i++) begin
            idx = last_q + 2'(i + 1);
            if (!found && req[idx]) begin
                win   = idx;
                found = 1'b1;
            end
        end
    end
`else
    always_comb begin
        if (req[3])      win = 2'd3;
        else if (req[2]) win = 2'd2;
        else if (req[1]) win = 2'd1;
        else             win = 2'd0;
    end
`endif

    assign hold_expired = (count_q == CNT_W'(HOLD_MAX - 1));
    assign release_now  = done || !req[out] || hold_expired;

    always_comb begin
        state_d   = state_q;
        grant_d   = grant;
        out_d     = out;
        flag_d    = flag;
        timeout_d = 1'b0;
        count_d   = count_q;
        last_d    = last_q;
        if (!enable) begin
            // Forced release: no gap, pointer untouched.
            state_d = IDLE;
            grant_d = 4'd0;
            out_d   = 2'd0;
            flag_d  = 1'b0;
            count_d = '0;
        end else begin
            case (state_q)
                IDLE: begin
                    grant_d = 4'd0;
                    out_d   = 2'd0;
                    flag_d  = 1'b0;
                    count_d = '0;
                    if (req != 4'd0) begin
                        grant_d = 4'b0001 << win;
                        out_d   = win;
                        flag_d  = 1'b1;
                        state_d = GRANT;
                    end
                end
                GRANT: begin
                    if (release_now) begin
                        grant_d   = 4'd0;
                        out_d     = 2'd0;
                        flag_d    = 1'b0;
                        last_d    = out;
                        timeout_d = !done && req[out];
                        state_d   = GAP;
                    end else if (count_q != {CNT_W{1'b1}}) begin
                        count_d = count_q + 1'b1;
                    end
                end
                GAP: begin
                    grant_d = 4'd0;
                    out_d   = 2'd0;
                    flag_d  = 1'b0;
                    state_d = IDLE;
                end
                default: begin
                    grant_d = 4'd0;
                    out_d   = 2'd0;
                    flag_d  = 1'b0;
                    count_d = '0;
                    state_d = IDLE;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            grant   <= 4'd0;
            out     <= 2'd0;
            flag    <= 1'b0;
            timeout <= 1'b0;
            count_q <= '0;
            last_q  <= 2'd3;
        end else begin
            state_q <= state_d;
            grant   <= grant_d;
            out     <= out_d;
            flag    <= flag_d;
            timeout <= timeout_d;
            count_q <= count_d;
            last_q  <= last_d;
        end
    end

endmodule
